// File: rtl/fib_seq_gen_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
package fib_pkg;

    typedef enum logic [1:0] {
        FIB_IDLE = 2'd0,
        FIB_RUN  = 2'd1,
        FIB_DONE = 2'd2
    } fib_state_e;

    localparam logic FIB_MODE_STOP = 1'b0;
    localparam logic FIB_MODE_WRAP = 1'b1;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Control and output-stream bundle of fib_seq_gen.
// term_idx exists only when FIB_TERM_IDX_EN is defined.
interface fib_seq_gen_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed_a;
    logic [WIDTH-1:0] seed_b;
    logic             wrap_mode;
    logic [IDX_W-1:0] max_terms;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
    logic             ovf;
`ifdef FIB_TERM_IDX_EN
    logic [IDX_W-1:0] term_idx;
`endif

    modport master (
        input  start, seed_a, seed_b, wrap_mode, max_terms, out_ready,
`ifdef FIB_TERM_IDX_EN
        output term_idx,
`endif
        output out_valid, out_data, busy, done, ovf
    );

    modport slave (
        output start, seed_a, seed_b, wrap_mode, max_terms, out_ready,
`ifdef FIB_TERM_IDX_EN
        input  term_idx,
`endif
        input  out_valid, out_data, busy, done, ovf
    );

endinterface

// File: rtl/fib_seq_gen_step_add.sv
// Combinational WIDTH-bit adder producing the next term and its overflow carry.
module fib_step_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out
);

    assign {o_carry_out, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci-style term generator with programmable seeds, term limit and overflow mode.
// Optional FIB_TERM_IDX_EN adds a registered term_idx aligned with out_data.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    fib_seq_gen_if.master bus
);

    fib_state_e       r_state,  w_state_nxt;
    logic             r_valid,  w_valid_nxt;
    logic [WIDTH-1:0] r_cur,    w_cur_nxt;
    logic [WIDTH-1:0] r_nxt,    w_nxt_nxt;
    logic             r_last,   w_last_nxt;
    logic             r_ovf,    w_ovf_nxt;
    logic [IDX_W-1:0] r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0] r_seed_a, w_seed_a_nxt;
    logic [WIDTH-1:0] r_seed_b, w_seed_b_nxt;
    logic             r_wrap,   w_wrap_nxt;
    logic [IDX_W-1:0] r_max,    w_max_nxt;
    logic             r_busy;
    logic             r_done;
`ifdef FIB_TERM_IDX_EN
    logic [IDX_W-1:0] r_idx,    w_idx_nxt;
`endif

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_fire;
    logic             w_hit_max;

    fib_step_add #(.WIDTH(WIDTH)) u_step_add (
        .i_a         (r_cur),
        .i_b         (r_nxt),
        .o_sum       (w_sum),
        .o_carry_out (w_carry)
    );

    assign w_fire    = r_valid & bus.out_ready;
    assign w_hit_max = (r_max != {IDX_W{1'b0}}) && (r_cnt == (r_max - IDX_W'(1)));

    // r_last marks the presented term as the final representable one (its successor carried out)
    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_cur_nxt    = r_cur;
        w_nxt_nxt    = r_nxt;
        w_last_nxt   = r_last;
        w_ovf_nxt    = r_ovf;
        w_cnt_nxt    = r_cnt;
        w_seed_a_nxt = r_seed_a;
        w_seed_b_nxt = r_seed_b;
        w_wrap_nxt   = r_wrap;
        w_max_nxt    = r_max;
`ifdef FIB_TERM_IDX_EN
        w_idx_nxt    = r_idx;
`endif
        case (r_state)
            FIB_IDLE, FIB_DONE: begin
                if (bus.start) begin
                    w_state_nxt  = FIB_RUN;
                    w_valid_nxt  = 1'b1;
                    w_cur_nxt    = bus.seed_a;
                    w_nxt_nxt    = bus.seed_b;
                    w_last_nxt   = 1'b0;
                    w_ovf_nxt    = 1'b0;
                    w_cnt_nxt    = {IDX_W{1'b0}};
                    w_seed_a_nxt = bus.seed_a;
                    w_seed_b_nxt = bus.seed_b;
                    w_wrap_nxt   = bus.wrap_mode;
                    w_max_nxt    = bus.max_terms;
`ifdef FIB_TERM_IDX_EN
                    w_idx_nxt    = {IDX_W{1'b0}};
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            FIB_RUN: begin
                if (w_fire) begin
                    // The term limit wins over both overflow behaviours
                    if (w_hit_max) begin
                        w_state_nxt = FIB_DONE;
                        w_valid_nxt = 1'b0;
                    end else if (r_last && (r_wrap == FIB_MODE_STOP)) begin
                        w_state_nxt = FIB_DONE;
                        w_valid_nxt = 1'b0;
                        w_ovf_nxt   = 1'b1;
                    end else if (r_last && (r_wrap == FIB_MODE_WRAP)) begin
                        w_ovf_nxt  = 1'b1;
                        w_cur_nxt  = r_seed_a;
                        w_nxt_nxt  = r_seed_b;
                        w_last_nxt = 1'b0;
                        w_cnt_nxt  = r_cnt + IDX_W'(1);
`ifdef FIB_TERM_IDX_EN
                        w_idx_nxt  = r_idx + IDX_W'(1);
`endif
                    end else begin
                        w_cur_nxt  = r_nxt;
                        w_nxt_nxt  = w_sum;
                        w_last_nxt = w_carry;
                        w_cnt_nxt  = r_cnt + IDX_W'(1);
`ifdef FIB_TERM_IDX_EN
                        w_idx_nxt  = r_idx + IDX_W'(1);
`endif
                    end
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            default: begin
                w_state_nxt = FIB_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, term and shadow registers; busy/done are decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FIB_IDLE;
            r_valid  <= 1'b0;
            r_cur    <= {WIDTH{1'b0}};
            r_nxt    <= {WIDTH{1'b0}};
            r_last   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= {IDX_W{1'b0}};
            r_seed_a <= {WIDTH{1'b0}};
            r_seed_b <= {WIDTH{1'b0}};
            r_wrap   <= 1'b0;
            r_max    <= {IDX_W{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef FIB_TERM_IDX_EN
            r_idx    <= {IDX_W{1'b0}};
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_cur    <= w_cur_nxt;
            r_nxt    <= w_nxt_nxt;
            r_last   <= w_last_nxt;
            r_ovf    <= w_ovf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_seed_a <= w_seed_a_nxt;
            r_seed_b <= w_seed_b_nxt;
            r_wrap   <= w_wrap_nxt;
            r_max    <= w_max_nxt;
            r_busy   <= (w_state_nxt == FIB_RUN);
            r_done   <= (w_state_nxt == FIB_DONE);
`ifdef FIB_TERM_IDX_EN
            r_idx    <= w_idx_nxt;
`endif
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_cur;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ovf       = r_ovf;
`ifdef FIB_TERM_IDX_EN
    assign bus.term_idx  = r_idx;
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: a 4-bit and a 16-bit instance share one stimulus
// source; expected terms come from a lap list computed with plain integer arithmetic.
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel4 = 1'b0;
    logic        start = 1'b0;
    logic [15:0] seed_a = 16'h0000;
    logic [15:0] seed_b = 16'h0000;
    logic        wrap = 1'b0;
    logic [7:0]  max_terms = 8'h00;
    logic        out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    longint lap_q[$];

    always #5 clk = ~clk;

    fib_seq_gen_if #(.WIDTH(4),  .IDX_W(8)) if4  ();
    fib_seq_gen_if #(.WIDTH(16), .IDX_W(8)) if16 ();

    fib_seq_gen #(.WIDTH(4),  .IDX_W(8)) u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    fib_seq_gen #(.WIDTH(16), .IDX_W(8)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    assign if4.start      = start & sel4;
    assign if4.seed_a     = seed_a[3:0];
    assign if4.seed_b     = seed_b[3:0];
    assign if4.wrap_mode  = wrap;
    assign if4.max_terms  = max_terms;
    assign if4.out_ready  = out_ready;
    assign if16.start     = start & ~sel4;
    assign if16.seed_a    = seed_a;
    assign if16.seed_b    = seed_b;
    assign if16.wrap_mode = wrap;
    assign if16.max_terms = max_terms;
    assign if16.out_ready = out_ready;

    logic        o_valid, o_busy, o_done, o_ovf;
    logic [15:0] o_data;
    assign o_valid = sel4 ? if4.out_valid : if16.out_valid;
    assign o_busy  = sel4 ? if4.busy      : if16.busy;
    assign o_done  = sel4 ? if4.done      : if16.done;
    assign o_ovf   = sel4 ? if4.ovf       : if16.ovf;
    assign o_data  = sel4 ? {12'h000, if4.out_data} : if16.out_data;
`ifdef FIB_TERM_IDX_EN
    logic [7:0] o_idx;
    assign o_idx = sel4 ? if4.term_idx : if16.term_idx;
`endif

    // One lap: t0, t1, then sums until the first sum that does not fit in w bits
    function automatic void build_lap(input int w, input longint a, input longint b);
        longint lim;
        longint s;
        lim = longint'(1) << w;
        lap_q.delete();
        lap_q.push_back(a);
        lap_q.push_back(b);
        while (lap_q.size() < 300) begin
            s = lap_q[lap_q.size() - 1] + lap_q[lap_q.size() - 2];
            if (s >= lim) break;
            lap_q.push_back(s);
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seq(input string name, input bit use4, input longint a, input longint b,
                           input bit wr, input int mx, input int n_emit, input int rdy_pct);
        int n, e_total, e, cycles, budget;
        bit ends_done, fin_ovf, rdy;
        logic [15:0] exp_d;
        build_lap(use4 ? 4 : 16, a, b);
        n = lap_q.size();
        if (mx != 0) e_total = (!wr && n < mx) ? n : mx;
        else         e_total = wr ? n_emit : n;
        ends_done = (mx != 0) || !wr;
        fin_ovf   = (e_total > n) || (!wr && e_total == n && mx != n);
        budget    = e_total * 20 + 50;
        sel4 = use4; seed_a = a[15:0]; seed_b = b[15:0]; wrap = wr; max_terms = mx[7:0];
        out_ready = 1'b0;
        pulse_start();
        e = 0;
        cycles = 0;
        while (e < e_total && cycles < budget) begin
            exp_d = 16'(lap_q[e % n]);
            n_vec++;
            if (o_valid !== 1'b1) begin n_err++; $display("FAIL %s valid e=%0d got %b want 1", name, e, o_valid); end
            n_vec++;
            if (o_data !== exp_d) begin n_err++; $display("FAIL %s data e=%0d got %0d want %0d", name, e, o_data, exp_d); end
            n_vec++;
            if (o_ovf !== (e >= n)) begin n_err++; $display("FAIL %s ovf e=%0d got %b want %b", name, e, o_ovf, (e >= n)); end
            n_vec++;
            if ({o_busy, o_done} !== 2'b10) begin n_err++; $display("FAIL %s busy_done e=%0d got %b want 10", name, e, {o_busy, o_done}); end
`ifdef FIB_TERM_IDX_EN
            n_vec++;
            if (o_idx !== 8'(e)) begin n_err++; $display("FAIL %s term_idx e=%0d got %0d want %0d", name, e, o_idx, 8'(e)); end
`endif
            rdy = ($urandom_range(99) < rdy_pct);
            out_ready = rdy;
            if (rdy) e++;
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        n_vec++;
        if (e < e_total) begin n_err++; $display("FAIL %s timeout got %0d terms want %0d", name, e, e_total); end
        if (ends_done) begin
            n_vec++;
            if ({o_valid, o_busy, o_done} !== 3'b001) begin
                n_err++; $display("FAIL %s end_state got v/b/d=%b want 001", name, {o_valid, o_busy, o_done});
            end
            n_vec++;
            if (o_ovf !== fin_ovf) begin n_err++; $display("FAIL %s end_ovf got %b want %b", name, o_ovf, fin_ovf); end
        end else begin
            pulse_reset();
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel4 = s[0];
            #1;
            n_vec++;
            if ({o_valid, o_busy, o_done, o_ovf, o_data} !== 20'h00000) begin
                n_err++; $display("FAIL reset sel4=%0d got v/b/d/o=%b data=%0d want all 0", s, {o_valid, o_busy, o_done, o_ovf}, o_data);
            end
`ifdef FIB_TERM_IDX_EN
            n_vec++;
            if (o_idx !== 8'h00) begin n_err++; $display("FAIL reset_idx got %0d want 0", o_idx); end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_overflow_stop();
        run_seq("ovf_stop_w4", 1'b1, 0, 1, 1'b0, 0, 0, 100);
        run_seq("seed_ovf_w4", 1'b1, 12, 9, 1'b0, 0, 0, 100);
    endtask

    task automatic test_overflow_wrap();
        run_seq("ovf_wrap_w4", 1'b1, 0, 1, 1'b1, 0, 14, 100);
    endtask

    task automatic test_max_terms();
        run_seq("max5_w16", 1'b0, 2, 3, 1'b0, 5, 0, 100);
        run_seq("zero_seeds", 1'b0, 0, 0, 1'b1, 10, 0, 70);
        run_seq("max_wrap_w4", 1'b1, 3, 5, 1'b1, 9, 0, 100);
    endtask

    task automatic test_backpressure();
        longint a, b;
        bit u4, wr;
        int mx;
        for (int it = 0; it < 10; it++) begin
            u4 = 1'($urandom_range(1));
            a  = longint'($urandom_range(u4 ? 15 : 65535));
            b  = longint'($urandom_range(u4 ? 15 : 65535));
            wr = 1'($urandom_range(1));
            mx = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(40, 1));
            if (a == 0 && b == 0 && mx == 0) mx = 10;
            run_seq("random_bp", u4, a, b, wr, mx, 40, 50);
        end
    endtask

    task automatic test_start_in_run();
        logic [15:0] exp_t [3];
        exp_t[0] = 16'd1; exp_t[1] = 16'd1; exp_t[2] = 16'd2;
        sel4 = 1'b0; seed_a = 16'd1; seed_b = 16'd1; wrap = 1'b0; max_terms = 8'd3;
        out_ready = 1'b0;
        pulse_start();
        seed_a = 16'd9; seed_b = 16'd9;
        pulse_start();
        n_vec++;
        if ({o_valid, o_busy, o_data} !== {2'b11, 16'd1}) begin
            n_err++; $display("FAIL start_in_run got v/b=%b data=%0d want 11 data=1", {o_valid, o_busy}, o_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (o_data !== exp_t[k]) begin n_err++; $display("FAIL start_in_run term%0d got %0d want %0d", k, o_data, exp_t[k]); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_vec++;
        if ({o_valid, o_done} !== 2'b01) begin n_err++; $display("FAIL start_in_run end got v/d=%b want 01", {o_valid, o_done}); end
        run_seq("start_in_done", 1'b0, 5, 5, 1'b0, 3, 0, 100);
    endtask

    task automatic test_reset_mid_run();
        sel4 = 1'b0; seed_a = 16'd1; seed_b = 16'd2; wrap = 1'b1; max_terms = 8'd0;
        out_ready = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({o_valid, o_busy, o_done, o_ovf, o_data} !== 20'h00000) begin
            n_err++; $display("FAIL reset_mid_run got v/b/d/o=%b data=%0d want all 0", {o_valid, o_busy, o_done, o_ovf}, o_data);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_seq("restart", 1'b0, 3, 4, 1'b0, 6, 0, 70);
    endtask

    initial begin
        test_reset();
        test_overflow_stop();
        test_overflow_wrap();
        test_max_terms();
        test_start_in_run();
        test_reset_mid_run();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
